// File: rtl/term_ingress_fifo_pkg.sv
// Shared router definitions used by the terminal ingress FIFO: header field
// offsets, counter width, occupancy FSM states and the broadcast-pattern test.
package term_ingress_fifo_pkg;

  // Header field MSB positions, counted down from the packet MSB (pckg_sz - ofs).
  localparam int unsigned RowMsbOfs  = 9;
  localparam int unsigned ColMsbOfs  = 13;
  localparam int unsigned ModeMsbOfs = 17;
  localparam int unsigned AddrFieldW = 4;

  // Width of the rejection statistics counters.
  localparam int unsigned CntWidth = 16;

  typedef enum logic [0:0] {
    StEmpty,
    StActive
  } occ_state_e;

  // True when the low 'width' bits of 'field' are all ones.
  function automatic logic is_broadcast(input logic [63:0] field, input int unsigned width);
    logic all_ones;
    all_ones = 1'b1;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width && !field[i]) all_ones = 1'b0;
    end
    return all_ones;
  endfunction

endpackage

// File: rtl/term_fifo_mem.sv
// Packet storage for the ingress FIFO: synchronous write, asynchronous read.
// Contents are not reset; the controller masks the read data while empty.
module term_fifo_mem #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [Depth];

  // Write port: store the accepted packet at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/term_ingress_fifo.sv
// Terminal-to-router ingress FIFO, first-word-fall-through, with overflow and
// (optionally) address-check drop statistics.
// Build option: define TERM_ADDR_CHECK_EN to reject pushes addressed outside
// the ROWS x COLUMS mesh (broadcast payloads always pass).
module term_ingress_fifo
  import term_ingress_fifo_pkg::*;
#(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic [pckg_sz-1:0]                  data_in,
  output logic                                full,
  output logic                                pndng,
  output logic [pckg_sz-1:0]                  data_out,
  input  logic                                popin,
  output logic [$clog2(fifo_depth+1)-1:0]     count,
  output logic [CntWidth-1:0]                 ovf_cnt,
  output logic [CntWidth-1:0]                 drop_cnt
);

  localparam int unsigned PtrW   = $clog2(fifo_depth);
  localparam int unsigned CountW = $clog2(fifo_depth + 1);

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [CntWidth-1:0] ovf_q, ovf_d;
  occ_state_e          state_q, state_d;
  logic [pckg_sz-1:0]  rd_data;

  logic addr_ok;
  logic pop_eff;
  logic push_acc;
  logic push_ovf;

`ifdef TERM_ADDR_CHECK_EN
  logic [AddrFieldW-1:0] tgt_row;
  logic [AddrFieldW-1:0] tgt_col;
  logic                  bcast;
  logic [CntWidth-1:0]   drop_q, drop_d;

  assign tgt_row = data_in[pckg_sz-RowMsbOfs -: AddrFieldW];
  assign tgt_col = data_in[pckg_sz-ColMsbOfs -: AddrFieldW];
  assign bcast   = is_broadcast(64'(data_in[pckg_sz-ModeMsbOfs:0]), pckg_sz - ModeMsbOfs + 1);

  // Out-of-mesh targets are rejected unless the payload is the broadcast pattern.
  always_comb begin
    addr_ok = 1'b1;
    if (!bcast && ((32'(tgt_row) >= ROWS) || (32'(tgt_col) >= COLUMS))) addr_ok = 1'b0;
  end

  // Address-rejection counter, saturating.
  always_comb begin
    drop_d = drop_q;
    if (push && !addr_ok && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign addr_ok  = 1'b1;
  assign drop_cnt = '0;
`endif

  assign full    = (count_q == CountW'(fifo_depth));
  assign pop_eff = popin && (state_q == StActive);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc = push && addr_ok && (!full || pop_eff);
  assign push_ovf = push && addr_ok && full && !pop_eff;

  // Pointer, occupancy and overflow-counter next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_acc) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(fifo_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(fifo_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_acc && !pop_eff) count_d = count_q + 1'b1;
    if (!push_acc && pop_eff) count_d = count_q - 1'b1;
    if (push_ovf && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
  end

  // Occupancy FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty:  if (push_acc) state_d = StActive;
      StActive: if (pop_eff && !push_acc && (count_q == CountW'(1))) state_d = StEmpty;
      default:  state_d = StEmpty;
    endcase
  end

  // State registers; reset discards all stored packets by clearing occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      state_q  <= StEmpty;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  term_fifo_mem #(
    .Width (pckg_sz),
    .Depth (fifo_depth)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign pndng    = (state_q == StActive);
  assign data_out = pndng ? rd_data : '0;
  assign count    = count_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_term_ingress_fifo.sv
// Scoreboard bench for term_ingress_fifo: stimulus queues expected packets,
// per-instance monitors compare the head whenever a pop is presented.
module tb_term_ingress_fifo;

  localparam int W = 40;

  logic         clk = 1'b0;
  logic         reset = 1'b0;

  // Depth-4 instance
  logic         push = 1'b0, popin = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         full, pndng;
  logic [W-1:0] data_out;
  logic [2:0]   count;
  logic [15:0]  ovf_cnt, drop_cnt;

  // Depth-3 instance
  logic         push3 = 1'b0, popin3 = 1'b0;
  logic [W-1:0] data_in3 = '0;
  logic         full3, pndng3;
  logic [W-1:0] data_out3;
  logic [1:0]   count3;
  logic [15:0]  ovf_cnt3, drop_cnt3;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];

  term_ingress_fifo #(.pckg_sz(W), .fifo_depth(4), .ROWS(4), .COLUMS(4)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full), .pndng(pndng),
    .data_out(data_out), .popin(popin), .count(count), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
  );

  term_ingress_fifo #(.pckg_sz(W), .fifo_depth(3), .ROWS(4), .COLUMS(4)) dut3 (
    .clk(clk), .reset(reset), .push(push3), .data_in(data_in3), .full(full3), .pndng(pndng3),
    .data_out(data_out3), .popin(popin3), .count(count3), .ovf_cnt(ovf_cnt3),
    .drop_cnt(drop_cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare the head of the depth-4 FIFO on every effective pop.
  always @(negedge clk) begin
    if (!reset && popin && pndng) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_data unexpected actual=%0h required=none", data_out);
      end else begin
        chk("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  // Monitor for the depth-3 FIFO.
  always @(negedge clk) begin
    if (!reset && popin3 && pndng3) begin
      if (exp3_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop3_data unexpected actual=%0h required=none", data_out3);
      end else begin
        chk("pop3_data", data_out3, exp3_q.pop_front());
      end
    end
  end

  task automatic step(input logic p, input logic [W-1:0] d, input logic q);
    push = p; data_in = d; popin = q;
    @(posedge clk); #1;
    push = 1'b0; data_in = '0; popin = 1'b0;
  endtask

  task automatic step3(input logic p, input logic [W-1:0] d, input logic q);
    push3 = p; data_in3 = d; popin3 = q;
    @(posedge clk); #1;
    push3 = 1'b0; data_in3 = '0; popin3 = 1'b0;
  endtask

  // Push and record the packet in the scoreboard when it is expected to be taken.
  task automatic wr(input logic [W-1:0] d, input logic acc);
    if (acc) exp_q.push_back(d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic wr3(input logic [W-1:0] d, input logic acc);
    if (acc) exp3_q.push_back(d);
    step3(1'b1, d, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] p1;
    logic [W-1:0] d;
    p1 = 40'h01_2_3_0_ABCDE;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_pndng", pndng, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single packet
    wr(p1, 1'b1);
    chk("single_pndng", pndng, 1);
    chk("single_data", data_out, p1);
    chk("single_count", count, 1);
    step(1'b0, '0, 1'b1);
    chk("single_pop_pndng", pndng, 0);
    chk("single_pop_data", data_out, 0);
    // Pop while empty is ignored
    step(1'b0, '0, 1'b1);
    chk("empty_pop_count", count, 0);
    chk("empty_pop_pndng", pndng, 0);

    // Overflow: six pushes into depth 4
    for (int i = 0; i < 6; i++) begin
      d = 40'h01_1_1_0_00001 + 40'(i);
      wr(d, i < 4);
    end
    chk("ovf_count", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_cnt", ovf_cnt, 2);

    // Push and pop together while full: new packet becomes 4th out
    d = 40'h01_1_1_0_00077;
    exp_q.push_back(d);
    step(1'b1, d, 1'b1);
    chk("fullpp_count", count, 4);
    chk("fullpp_ovf", ovf_cnt, 2);
    chk("fullpp_full", full, 1);
    repeat (4) step(1'b0, '0, 1'b1);
    chk("drain_count", count, 0);
    chk("drain_full", full, 0);

    // Push and pop together at count 1
    wr(40'h01_0_0_0_00100, 1'b1);
    exp_q.push_back(40'h01_0_0_0_00200);
    step(1'b1, 40'h01_0_0_0_00200, 1'b1);
    chk("one_pp_count", count, 1);
    chk("one_pp_data", data_out, 40'h01_0_0_0_00200);
    step(1'b0, '0, 1'b1);
    chk("one_pp_empty", pndng, 0);

    // Address check: row 5, broadcast with row 5, column 7
`ifdef TERM_ADDR_CHECK_EN
    wr(40'h01_5_1_0_00010, 1'b0);
    chk("addr_row_drop", drop_cnt, 1);
    chk("addr_row_count", count, 0);
    wr(40'h01_5_1_FFFFFF, 1'b1);
    chk("addr_bcast_count", count, 1);
    wr(40'h01_1_7_0_00020, 1'b0);
    chk("addr_col_drop", drop_cnt, 2);
    chk("addr_ovf_same", ovf_cnt, 2);
    step(1'b0, '0, 1'b1);
`else
    wr(40'h01_5_1_0_00010, 1'b1);
    wr(40'h01_5_1_FFFFFF, 1'b1);
    wr(40'h01_1_7_0_00020, 1'b1);
    chk("addr_off_count", count, 3);
    chk("addr_off_drop", drop_cnt, 0);
    repeat (3) step(1'b0, '0, 1'b1);
`endif
    chk("addr_end_count", count, 0);

    // Reset mid-operation with three packets stored
    for (int i = 0; i < 3; i++) wr(40'h01_3_3_0_00300 + 40'(i), 1'b1);
    chk("pre_rst_count", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pndng", pndng, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    chk("mid_rst_full", full, 0);
    #1 reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("post_rst_pndng", pndng, 0);
    step(1'b0, '0, 1'b1);
    chk("post_rst_pop_pndng", pndng, 0);
    chk("post_rst_count", count, 0);
    wr(40'h01_2_2_0_00555, 1'b1);
    chk("post_rst_new", data_out, 40'h01_2_2_0_00555);
    step(1'b0, '0, 1'b1);

    // Depth 3: wrap-around with ten push/pop pairs at occupancy 2
    wr3(40'h01_0_1_0_10000, 1'b1);
    wr3(40'h01_0_1_0_10001, 1'b1);
    chk("d3_count_2", count3, 2);
    for (int i = 2; i < 12; i++) begin
      d = 40'h01_0_1_0_10000 + 40'(i);
      exp3_q.push_back(d);
      step3(1'b1, d, 1'b1);
    end
    chk("d3_pairs_count", count3, 2);
    chk("d3_pairs_ovf", ovf_cnt3, 0);
    repeat (2) step3(1'b0, '0, 1'b1);
    chk("d3_drain_count", count3, 0);
    chk("d3_drain_pndng", pndng3, 0);
    // Depth 3 full boundary
    for (int i = 0; i < 4; i++) wr3(40'h01_1_2_0_20000 + 40'(i), i < 3);
    chk("d3_full", full3, 1);
    chk("d3_full_count", count3, 3);
    chk("d3_ovf", ovf_cnt3, 1);
    repeat (3) step3(1'b0, '0, 1'b1);
    chk("d3_end_count", count3, 0);

    chk("sb_drain", 64'(exp_q.size()), 0);
    chk("sb3_drain", 64'(exp3_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
